// File: rtl/uart_fifo_xcvr.sv
// Full-duplex UART transceiver with TX/RX FIFOs and a configurable frame format.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   UART_rxd / UART_txd        serial line in (asynchronous) / out (idle high)
//   tx_data, tx_valid, tx_ready TX FIFO write side
//   rx_data, rx_err, rx_valid, rx_ready
//                              RX FIFO head (zero when empty) and pop handshake;
//                              rx_err[0] = parity error, rx_err[1] = framing error
//   rx_overrun, clear_overrun  sticky dropped-byte flag and its synchronous clear
//   tx_busy                    serializer not idle
//   tx_count, rx_count         FIFO occupancy
module uart_fifo_xcvr #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_rxd,
  output logic                 UART_txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [1:0]           rx_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clear_overrun,
  output logic                 tx_busy,
  output logic [CW-1:0]        tx_count,
  output logic [CW-1:0]        rx_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int unsigned BW   = $clog2(DATA_BITS);

  localparam logic [CNTW-1:0] BitLast    = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] StopLast   = CNTW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HalfBit    = CNTW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0]   BitIdxLast = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0]   Full       = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4) begin : g_chk_baud
    $error("uart_fifo_xcvr: CLK_FREQ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
    $error("uart_fifo_xcvr: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_fifo_xcvr: FIFO_DEPTH must be a power of 2, at least 2");
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]        tx_wptr_q, tx_rptr_q;
  logic [CW-1:0]        tx_fill_q;
  logic                 tx_push, tx_pop;

  assign tx_ready = (tx_fill_q != Full);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_count = tx_fill_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_fill_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
      if (tx_push && !tx_pop)      tx_fill_q <= tx_fill_q + CW'(1);
      else if (tx_pop && !tx_push) tx_fill_q <= tx_fill_q - CW'(1);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNTW-1:0]      tx_tmr_q, tx_tmr_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
  logic                 txd_q, txd_d;
  logic                 tx_par;

  assign tx_par   = (PARITY == 1) ? ~^tx_byte_q : ^tx_byte_q;
  assign tx_busy  = (tx_state_q != TxIdle);
  assign UART_txd = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    case (tx_state_q)
      TxIdle: begin
        if (tx_fill_q != '0) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_mem_q[tx_rptr_q];
          tx_tmr_d   = BitLast;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        txd_d = 1'b0;
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = BitLast;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_tmr_d = tx_tmr_q - CNTW'(1);
        end
      end
      TxData: begin
        txd_d = tx_byte_q[tx_bit_q];
        if (tx_tmr_q == '0) begin
          tx_tmr_d = BitLast;
          tx_bit_d = tx_bit_q + BW'(1);
          if (tx_bit_q == BitIdxLast) begin
            if (PARITY != 0) begin
              tx_state_d = TxParity;
            end else begin
              tx_tmr_d   = StopLast;
              tx_state_d = TxStop;
            end
          end
        end else begin
          tx_tmr_d = tx_tmr_q - CNTW'(1);
        end
      end
      TxParity: begin
        txd_d = tx_par;
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = StopLast;
          tx_state_d = TxStop;
        end else begin
          tx_tmr_d = tx_tmr_q - CNTW'(1);
        end
      end
      TxStop: begin
        if (tx_tmr_q == '0) tx_state_d = TxIdle;
        else                tx_tmr_d   = tx_tmr_q - CNTW'(1);
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic [1:0]           rx_sync_q;
  logic                 rxs;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNTW-1:0]      rx_tmr_q, rx_tmr_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_exp_par;
  logic                 rx_push;
  logic [DATA_BITS+1:0] rx_word;

  assign rxs        = rx_sync_q[1];
  assign rx_exp_par = (PARITY == 1) ? ~^rx_sh_q : ^rx_sh_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_word    = {~rxs, rx_perr_q, rx_sh_q};
    case (rx_state_q)
      RxIdle: begin
        if (!rxs) begin
          rx_tmr_d   = HalfBit;
          rx_perr_d  = 1'b0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_tmr_q == '0) begin
          // Line back high at mid-start: treat as a glitch.
          if (rxs) begin
            rx_state_d = RxIdle;
          end else begin
            rx_tmr_d   = BitLast;
            rx_bit_d   = '0;
            rx_state_d = RxData;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - CNTW'(1);
        end
      end
      RxData: begin
        if (rx_tmr_q == '0) begin
          rx_sh_d[rx_bit_q] = rxs;
          rx_tmr_d          = BitLast;
          rx_bit_d          = rx_bit_q + BW'(1);
          if (rx_bit_q == BitIdxLast) rx_state_d = (PARITY != 0) ? RxParity : RxStop;
        end else begin
          rx_tmr_d = rx_tmr_q - CNTW'(1);
        end
      end
      RxParity: begin
        if (rx_tmr_q == '0) begin
          rx_perr_d  = (rxs != rx_exp_par);
          rx_tmr_d   = BitLast;
          rx_state_d = RxStop;
        end else begin
          rx_tmr_d = rx_tmr_q - CNTW'(1);
        end
      end
      RxStop: begin
        // Only the first stop bit is sampled; the byte is pushed even if flagged.
        if (rx_tmr_q == '0) begin
          rx_push    = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_tmr_d = rx_tmr_q - CNTW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], UART_rxd};
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS+1:0] rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]        rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]        rx_fill_q;
  logic                 rx_overrun_q;
  logic                 rx_full, rx_pop, rx_wr, rx_drop;
  logic [DATA_BITS+1:0] rx_head;

  assign rx_full    = (rx_fill_q == Full);
  assign rx_valid   = (rx_fill_q != '0);
  assign rx_pop     = rx_ready && rx_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign rx_wr      = rx_push && (!rx_full || rx_pop);
  assign rx_drop    = rx_push && rx_full && !rx_pop;
  assign rx_head    = rx_mem_q[rx_rptr_q];
  assign rx_data    = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
  assign rx_err     = rx_valid ? rx_head[DATA_BITS+:2] : 2'b00;
  assign rx_count   = rx_fill_q;
  assign rx_overrun = rx_overrun_q;

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wptr_q] <= rx_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_fill_q    <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + PW'(1);
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PW'(1);
      if (rx_wr && !rx_pop)      rx_fill_q <= rx_fill_q + CW'(1);
      else if (rx_pop && !rx_wr) rx_fill_q <= rx_fill_q - CW'(1);
      if (rx_drop)            rx_overrun_q <= 1'b1;
      else if (clear_overrun) rx_overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Bench for uart_fifo_xcvr: instance A is 8N1, instance B is 7E1, both with 4-entry FIFOs
// and 10 clocks per bit. Received bytes are checked against a scoreboard queue.
module tb_uart_fifo_xcvr;

  localparam int Cpb = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 8N1
  logic       drv_a, loop_a, rxd_a, txd_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic [1:0] rx_err_a;
  logic       ovr_a, clr_a, busy_a;
  logic [2:0] tx_cnt_a, rx_cnt_a;
  assign rxd_a = loop_a ? txd_a : drv_a;

  // Instance B: 7E1
  logic       drv_b, loop_b, rxd_b, txd_b;
  logic [6:0] tx_data_b, rx_data_b;
  logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic [1:0] rx_err_b;
  logic       ovr_b, clr_b, busy_b;
  logic [2:0] tx_cnt_b, rx_cnt_b;
  assign rxd_b = loop_b ? txd_b : drv_b;

  uart_fifo_xcvr #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .UART_rxd(rxd_a), .UART_txd(txd_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_err(rx_err_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_overrun(ovr_a), .clear_overrun(clr_a), .tx_busy(busy_a),
    .tx_count(tx_cnt_a), .rx_count(rx_cnt_a)
  );

  uart_fifo_xcvr #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .reset(reset), .UART_rxd(rxd_b), .UART_txd(txd_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_err(rx_err_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_overrun(ovr_b), .clear_overrun(clr_b), .tx_busy(busy_b),
    .tx_count(tx_cnt_b), .rx_count(rx_cnt_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] q_a[$];  // {err, data}
  logic [9:0] q_b[$];

  typedef struct {
    bit         dut;       // 0 = A (8N1), 1 = B (7E1)
    logic [7:0] data;
    bit         flip_par;
    bit         bad_stop;
    logic [7:0] exp_data;
    logic [1:0] exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b, input logic v);
    if (b) drv_b = v;
    else   drv_a = v;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic drive_frame(input bit b, input logic [7:0] d, input bit flip, input bit bad_stop);
    int   nbits;
    logic p;
    nbits = b ? 7 : 8;
    p     = 1'b0;
    send_bit(b, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(b, d[i]);
      p = p ^ d[i];
    end
    if (b) send_bit(b, p ^ flip);  // even parity
    send_bit(b, !bad_stop);
    send_bit(b, 1'b1);
    send_bit(b, 1'b1);
  endtask

  task automatic wait_rx(input bit b, input string name);
    bit         got;
    logic [9:0] exp;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (b ? rx_valid_b : rx_valid_a) got = 1'b1;
      else @(negedge clk);
    end
    check({name, " rx_valid"}, 32'(got), 32'd1);
    if (got && (b ? q_b.size() : q_a.size()) != 0) begin
      exp = b ? q_b.pop_front() : q_a.pop_front();
      check({name, " rx_data"}, b ? 32'(rx_data_b) : 32'(rx_data_a), 32'(exp[7:0]));
      check({name, " rx_err"},  b ? 32'(rx_err_b)  : 32'(rx_err_a),  32'(exp[9:8]));
      if (b) rx_ready_b = 1'b1;
      else   rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
      rx_ready_b = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         mm, bc, lows, t;
    logic       e;
    logic [7:0] a5;
    logic [6:0] d7;

    tbl[0] = '{dut: 0, data: 8'h55, flip_par: 0, bad_stop: 0, exp_data: 8'h55, exp_err: 2'b00};
    tbl[1] = '{dut: 0, data: 8'h3C, flip_par: 0, bad_stop: 1, exp_data: 8'h3C, exp_err: 2'b10};
    tbl[2] = '{dut: 0, data: 8'hC3, flip_par: 0, bad_stop: 0, exp_data: 8'hC3, exp_err: 2'b00};
    tbl[3] = '{dut: 0, data: 8'h00, flip_par: 0, bad_stop: 0, exp_data: 8'h00, exp_err: 2'b00};
    tbl[4] = '{dut: 1, data: 8'h41, flip_par: 1, bad_stop: 0, exp_data: 8'h41, exp_err: 2'b01};
    tbl[5] = '{dut: 1, data: 8'h41, flip_par: 0, bad_stop: 0, exp_data: 8'h41, exp_err: 2'b00};
    tbl[6] = '{dut: 1, data: 8'h7F, flip_par: 1, bad_stop: 0, exp_data: 8'h7F, exp_err: 2'b01};
    tbl[7] = '{dut: 1, data: 8'h2A, flip_par: 0, bad_stop: 1, exp_data: 8'h2A, exp_err: 2'b10};

    reset = 1'b1;
    drv_a = 1'b1; loop_a = 1'b0; tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
    clr_a = 1'b0;
    drv_b = 1'b1; loop_b = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
    clr_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset txd",        32'(txd_a),      32'd1);
    check("reset tx_ready",   32'(tx_ready_a), 32'd1);
    check("reset tx_busy",    32'(busy_a),     32'd0);
    check("reset rx_valid",   32'(rx_valid_a), 32'd0);
    check("reset rx_data",    32'(rx_data_a),  32'd0);
    check("reset rx_err",     32'(rx_err_a),   32'd0);
    check("reset rx_overrun", 32'(ovr_a),      32'd0);
    check("reset tx_count",   32'(tx_cnt_a),   32'd0);
    check("reset rx_count",   32'(rx_cnt_a),   32'd0);
    check("reset txd B",      32'(txd_b),      32'd1);

    // 8N1 loopback of 0xA5 with line waveform and busy-length check
    a5 = 8'hA5;
    loop_a = 1'b1;
    q_a.push_back({2'b00, a5});
    tx_data_a = a5; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    @(negedge clk);  // one edge after pop: line still idle
    mm = 0; bc = 0;
    for (int i = 0; i < 110; i++) begin
      if (i == 0)      e = 1'b1;
      else if (i < 11) e = 1'b0;
      else if (i < 91) e = a5[(i - 11) / 10];
      else             e = 1'b1;
      if (txd_a !== e) mm++;
      if (busy_a) bc++;
      @(negedge clk);
    end
    check("8N1 txd waveform mismatches", 32'(mm), 32'd0);
    check("8N1 tx_busy cycles", 32'(bc), 32'd100);
    wait_rx(0, "8N1 loopback");
    loop_a = 1'b0;

    // 7E1 transmit: parity bit on the line, then loopback
    d7 = 7'h41;
    loop_b = 1'b1;
    q_b.push_back({2'b00, 1'b0, d7});
    tx_data_b = d7; tx_valid_b = 1'b1;
    @(negedge clk);
    tx_valid_b = 1'b0;
    @(negedge clk);
    repeat (85) @(negedge clk);
    check("7E1 parity bit on line", 32'(txd_b), 32'(^d7));
    wait_rx(1, "7E1 loopback");
    loop_b = 1'b0;

    // Glitch reject: 3-clock low pulse must not start a byte
    drv_a = 1'b0;
    repeat (3) @(negedge clk);
    drv_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch rx_count", 32'(rx_cnt_a), 32'd0);
    check("glitch rx_valid", 32'(rx_valid_a), 32'd0);

    // Table-driven received frames
    for (int k = 0; k < 8; k++) begin
      if (tbl[k].dut) q_b.push_back({tbl[k].exp_err, tbl[k].exp_data});
      else            q_a.push_back({tbl[k].exp_err, tbl[k].exp_data});
      drive_frame(tbl[k].dut, tbl[k].data, tbl[k].flip_par, tbl[k].bad_stop);
      wait_rx(tbl[k].dut, $sformatf("vec%0d", k));
    end

    // Overrun: five bytes into a 4-entry FIFO with no pops
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_a.push_back({2'b00, 8'(k)});
      drive_frame(0, 8'(k), 1'b0, 1'b0);
    end
    check("overrun rx_count", 32'(rx_cnt_a), 32'd4);
    check("overrun flag set", 32'(ovr_a), 32'd1);
    for (int k = 0; k < 4; k++) wait_rx(0, $sformatf("overrun pop%0d", k));
    check("empty rx_valid", 32'(rx_valid_a), 32'd0);
    check("empty rx_data",  32'(rx_data_a),  32'd0);
    check("overrun still sticky", 32'(ovr_a), 32'd1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("overrun cleared", 32'(ovr_a), 32'd0);

    // Back-to-back TX, then reset mid second frame
    tx_valid_a = 1'b1; tx_data_a = 8'h11;
    @(negedge clk);
    tx_data_a = 8'h22;
    @(negedge clk);
    tx_data_a = 8'h33;
    @(negedge clk);
    tx_valid_a = 1'b0;
    check("b2b tx_count", 32'(tx_cnt_a), 32'd2);
    t = 0;
    while (txd_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b first start bit", 32'(txd_a), 32'd0);
    repeat (99) @(negedge clk);
    check("b2b stop bit", 32'(txd_a), 32'd1);
    @(negedge clk);
    check("b2b idle gap", 32'(txd_a), 32'd1);
    @(negedge clk);
    check("b2b second start at +101", 32'(txd_a), 32'd0);
    repeat (14) @(negedge clk);
    check("b2b frame2 bit0", 32'(txd_a), 32'd0);
    reset = 1'b1;
    #1;
    check("mid-frame reset txd", 32'(txd_a), 32'd1);
    check("mid-frame reset tx_count", 32'(tx_cnt_a), 32'd0);
    check("mid-frame reset tx_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!txd_a) lows++;
    end
    check("after reset no transmit", 32'(lows), 32'd0);
    check("after reset tx_ready", 32'(tx_ready_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_fifo_xcvr.md
# uart_fifo_xcvr

Parametrised full-duplex UART transceiver with configurable frame format (5–8 data bits, none/odd/even parity, 1 or 2 stop bits). It has independent TX and RX FIFOs behind ready/valid handshakes. RX includes a false-start filter, per-byte parity and framing error flags, and sticky overrun detection. It replaces the flattened fixed 8N1 TX/RX logic in the game top level, sitting between the board UART pins and the game controller.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD, 115_200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide); elaboration error if < 4
- DATA_BITS, 8, data bits per frame, legal 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, entries per FIFO, power of 2, ≥ 2; CW = $clog2(FIFO_DEPTH)+1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- UART_rxd  in  1  serial input, asynchronous to clk
- UART_txd  out  1  serial output, idle high
- tx_data  in  DATA_BITS  byte to transmit
- tx_valid  in  1  write request
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_BITS  head of RX FIFO; 0 when empty
- rx_err  out  2  head-entry flags: [0] parity error, [1] framing error; 0 when empty
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop request
- rx_overrun  out  1  sticky: a received byte was dropped
- clear_overrun  in  1  synchronous clear of rx_overrun
- tx_busy  out  1  TX serializer not idle
- tx_count, rx_count  out  CW  FIFO occupancy

## Operation
- Reset values: UART_txd = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, rx_err = 0, rx_overrun = 0, counts = 0. FIFO pointers and counts are cleared; FIFO memory is not reset.
- TX FIFO write occurs when tx_valid && tx_ready. A write while full is ignored.
- RX FIFO pop occurs when rx_ready && rx_valid. A pop while empty is ignored.
- RX push and pop in the same cycle are both honored, including when the FIFO is full (no overrun).
- Pointers wrap modulo FIFO_DEPTH. Each RX entry stores {err[1:0], data}.
- TX FSM: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
  - IDLE: if the TX FIFO is non-empty, pop, latch the byte, and go to START.
  - Each bit lasts CLKS_PER_BIT cycles. Data is sent LSB first.
  - Parity bit: odd parity = ~^data; even parity = ^data.
  - STOP lasts STOP_BITS × CLKS_PER_BIT cycles.
  - tx_busy = (state ≠ IDLE).
- RX input: UART_rxd passes through a 2-flop synchronizer before any use.
- RX FSM: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: a synchronized low loads the counter with CLKS_PER_BIT/2.
  - START: at the mid-bit sample, if the line is high, return to IDLE with no push (glitch reject). Otherwise proceed.
  - DATA: sample every CLKS_PER_BIT cycles after the start mid-point, shifting LSB first.
  - PARITY: perr = received bit ≠ expected bit.
  - STOP: sample only the first stop bit; ferr = (sample == 0).
  - Push at the stop-bit sample cycle, then go to IDLE immediately. A second stop bit is not checked.
  - The byte is pushed even when flagged with errors.
- Overrun: a push while full and not popping drops the incoming byte and sets rx_overrun. clear_overrun clears it. If set and clear coincide, set wins.
- Unused upper bits: when DATA_BITS < 8 only the low DATA_BITS bits of tx_data are used.

## Timing
- Frame length in clocks: F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS).
- TX latency: a write accepted at edge N into an empty FIFO with TX idle gives pop at edge N+1. UART_txd falls after edge N+2.
- Back-to-back TX frames have a period of F+1 clocks, including one idle-high cycle between frames.
- tx_ready deasserts the cycle after the write that fills the FIFO.
- RX latency: rx_valid rises the cycle after the stop-bit sample edge, which is ≈ 2 (sync) + CLKS_PER_BIT/2 cycles into the stop bit.
- rx_data and rx_err are combinational from the FIFO head and update the cycle after a pop.
- Reset mid-frame: UART_txd goes high and all FSMs return to IDLE asynchronously. A partially received byte is discarded.

## Test plan
Bench settings: CLK_FREQ = 1_000_000, BAUD = 100_000, so CLKS_PER_BIT = 10.
- 8N1 loopback: write 0xA5 → UART_txd is low for 10 clocks, then bits 1,0,1,0,0,1,0,1 for 10 clocks each, then high. Looped to UART_rxd → rx_valid with rx_data = 0xA5, rx_err = 00. tx_busy is high for exactly 100 clocks.
- 7E1: DATA_BITS = 7, PARITY = 2, send 0x41 → parity bit 0 on the line. Drive a frame with the parity bit flipped → rx_data = 0x41, rx_err = 01.
- Framing error: drive a frame for 0x3C with the stop bit low → byte pushed with rx_err = 10. The next good frame is received correctly.
- Glitch reject: 3-clock low pulse on UART_rxd → no push, rx_count stays 0. A following valid frame for 0x55 is received.
- Overrun: FIFO_DEPTH = 4, receive 0x01..0x05 with no pops → rx_count = 4, rx_overrun = 1, pops return 0x01..0x04. A clear_overrun pulse brings rx_overrun to 0.
- Back-to-back TX and reset: write 0x11, 0x22, 0x33 → start bits fall 101 clocks apart. Assert reset during the data bits of the second frame → UART_txd = 1 within the same cycle, tx_count = 0, and nothing further is transmitted.
